core_task_receiver: RTL and testbench
=====================================

// Module: core_task_receiver
// PURPOSE
//  Core-side end of the task-scheduler -> core instruction-load interface. One instance per core.
//  Captures the INSN_LOAD_TIME parts of one instruction frame and presents the assembled frame to the core executor.
//  Owns the core's Ready line and issues the R0 init write.
//  Sits between the scheduler buses (Start/Insn_Load_Counter/Insn_Data/Init_R0*) and the core pipeline.
// PARAMETERS
//  CORE_ID          0   index of this core in the Start/Ready/Init_R0_Vect vectors and the Init_R0 bus
//  NUM_OF_CORES     16  number of cores on the buses
//  INSN_LOAD_TIME   4   number of parts per frame (>=1); CNT_W = max(1,clog2(INSN_LOAD_TIME))
//  INSN_BUS_WIDTH   64  width of one Insn_Data part
//  REG_WIDTH        8   width of one core's R0 slice in Init_R0
// PORTS
//  clk               in   1                         clock, all state on rising edge
//  reset             in   1                         asynchronous, active-low reset
//  Start             in   NUM_OF_CORES              per-core part strobe; only bit CORE_ID is used
//  Insn_Load_Counter in   CNT_W                     index of the part currently on Insn_Data
//  Insn_Data         in   INSN_BUS_WIDTH            frame part
//  Init_R0_Vect      in   NUM_OF_CORES              bit CORE_ID=1: load R0 when the frame completes
//  Init_R0           in   NUM_OF_CORES*REG_WIDTH    R0 values; slice [CORE_ID*REG_WIDTH +: REG_WIDTH]
//  Ready             out  1                         1 = core idle, can accept a frame
//  frame_data        out  INSN_LOAD_TIME*INSN_BUS_WIDTH  assembled frame; part k at [k*INSN_BUS_WIDTH +: INSN_BUS_WIDTH]
//  exec_go           out  1                         1-cycle pulse: frame_data valid, start execution
//  exec_done         in   1                         executor finished the frame (pulse or level)
//  r0_wr_en          out  1                         1-cycle pulse, write r0_wr_data into R0
//  r0_wr_data        out  REG_WIDTH                 value for R0
//  proto_err         out  1                         sticky protocol-violation flag
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, Ready=1, exec_go=0, r0_wr_en=0, proto_err=0; frame_data=0, r0_wr_data=0, exp_cnt=0.
//  Strobe: st = Start[CORE_ID]. A part is accepted only when st=1 and Insn_Load_Counter==exp_cnt.
//    The accepted part is written into frame_data slot exp_cnt.
//  States:
//   IDLE (Ready=1):
//    - st & cnt==0 & INSN_LOAD_TIME>1 -> store part 0, exp_cnt=1, LOAD.
//    - st & cnt==0 & INSN_LOAD_TIME==1 -> complete (see below).
//    - st & cnt!=0 -> drop the part, proto_err=1, stay in IDLE.
//   LOAD (Ready=1):
//    - st=0 -> hold (scheduler stalled on another core); no timeout.
//    - st & cnt==exp_cnt < INSN_LOAD_TIME-1 -> store, exp_cnt+1.
//    - st & cnt==INSN_LOAD_TIME-1 -> store, complete.
//    - st & cnt!=exp_cnt -> proto_err=1, discard the partial frame, exp_cnt=0, IDLE.
//      Exception: if cnt==0, treat as a restart: store part 0, exp_cnt=1, stay in LOAD (proto_err still set).
//   Complete (same edge as the last part):
//    - Ready<=0 on that edge, so the scheduler sees the core busy on the next cycle.
//    - exec_go<=1 for exactly one cycle; state<=EXEC; exp_cnt<=0.
//    - If Init_R0_Vect[CORE_ID]=1 at that edge: r0_wr_en<=1 for one cycle, r0_wr_data<=Init_R0 slice.
//   EXEC (Ready=0):
//    - exec_done is ignored in the exec_go cycle; it is sampled from the following cycle on.
//    - exec_done=1 -> IDLE, Ready<=1 (1-cycle latency).
//    - st=1 in EXEC -> ignored, proto_err=1.
//  frame_data holds its value from completion until the next accepted part 0; it is stable throughout EXEC.
//  exp_cnt never exceeds INSN_LOAD_TIME-1 and has no wrap-around beyond that.
//  Insn_Data/Init_R0 are not sampled unless st=1 (Data) or on a completion edge (R0).
//  Reset mid-LOAD or mid-EXEC: immediate IDLE, Ready=1, and the partial frame is lost.
//  proto_err is cleared only by reset.
// TESTING
//  1 LOAD_TIME=4, Start[ID]=1 for 4 cycles, cnt 0..3, data A,B,C,D:
//    Ready falls on the 4th edge; exec_go pulses once; frame_data={D,C,B,A}.
//  2 Same frame as 1, but Start=0 for 3 cycles between cnt=1 and cnt=2:
//    state holds in LOAD, frame still {D,C,B,A}, proto_err=0.
//  3 Init_R0_Vect[ID]=1, Init_R0 slice=8'h5A at completion:
//    r0_wr_en pulses once with 8'h5A. With Init_R0_Vect[ID]=0: no pulse.
//  4 exec_done pulsed 5 cycles after exec_go: Ready=1 on the next cycle.
//    Start asserted during EXEC: proto_err=1, frame_data unchanged.
//  5 IDLE, Start with cnt=2 -> part dropped, proto_err=1, Ready=1.
//    In LOAD expecting 2, cnt=3 -> IDLE, partial frame discarded.
//  6 reset pulled low mid-LOAD (after part 1) -> Ready=1 and state=IDLE immediately.
//    A fresh 4-part frame after release loads correctly.

Source files
------------

// File: rtl/core_task_receiver.sv
// Core-side receiver for the scheduler's instruction-load bus.
// Assembles a multi-part frame, hands it to the executor, and drives Ready and the R0 init write.
module core_task_receiver #(
  parameter int unsigned CORE_ID        = 0,
  parameter int unsigned NUM_OF_CORES   = 16,
  parameter int unsigned INSN_LOAD_TIME = 4,
  parameter int unsigned INSN_BUS_WIDTH = 64,
  parameter int unsigned REG_WIDTH      = 8,
  localparam int unsigned CNT_W         = (INSN_LOAD_TIME > 2) ? $clog2(INSN_LOAD_TIME) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_OF_CORES-1:0]              Start,
  input  logic [CNT_W-1:0]                     Insn_Load_Counter,
  input  logic [INSN_BUS_WIDTH-1:0]            Insn_Data,
  input  logic [NUM_OF_CORES-1:0]              Init_R0_Vect,
  input  logic [NUM_OF_CORES*REG_WIDTH-1:0]    Init_R0,
  output logic                                 Ready,
  output logic [INSN_LOAD_TIME*INSN_BUS_WIDTH-1:0] frame_data,
  output logic                                 exec_go,
  input  logic                                 exec_done,
  output logic                                 r0_wr_en,
  output logic [REG_WIDTH-1:0]                 r0_wr_data,
  output logic                                 proto_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INSN_LOAD_TIME - 1);
  localparam bit               SINGLE   = (INSN_LOAD_TIME == 1);

  state_t                                  r_state;
  logic [CNT_W-1:0]                        r_exp_cnt;
  logic [INSN_LOAD_TIME*INSN_BUS_WIDTH-1:0] r_frame;
  logic                                    r_exec_go;
  logic                                    r_r0_wr_en;
  logic [REG_WIDTH-1:0]                    r_r0_wr_data;
  logic                                    r_proto_err;

  state_t           w_state_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_st;
  logic             w_store;
  logic             w_complete;
  logic             w_err;
  logic             w_r0_sel;
  logic             w_unused_bits;

  assign w_st          = Start[CORE_ID];
  assign w_r0_sel      = Init_R0_Vect[CORE_ID];
  assign w_unused_bits = ^{Start, Init_R0_Vect, Init_R0};

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_exp_cnt;
    w_store    = 1'b0;
    w_complete = 1'b0;
    w_err      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_st) begin
          if (Insn_Load_Counter == '0) begin
            w_store = 1'b1;
            if (SINGLE) begin
              w_complete = 1'b1;
            end else begin
              w_cnt_n   = CNT_W'(1);
              w_state_n = S_LOAD;
            end
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (w_st) begin
          if (Insn_Load_Counter == r_exp_cnt) begin
            w_store = 1'b1;
            if (Insn_Load_Counter == LAST_CNT) w_complete = 1'b1;
            else                               w_cnt_n    = r_exp_cnt + CNT_W'(1);
          end else begin
            w_err = 1'b1;
            // An out-of-order part 0 is taken as the scheduler restarting the frame.
            if (Insn_Load_Counter == '0) begin
              w_store = 1'b1;
              w_cnt_n = CNT_W'(1);
            end else begin
              w_cnt_n   = '0;
              w_state_n = S_IDLE;
            end
          end
        end
      end
      S_EXEC: begin
        if (w_st) w_err = 1'b1;
        if (exec_done && !r_exec_go) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_complete) begin
      w_state_n = S_EXEC;
      w_cnt_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_exp_cnt    <= '0;
      r_frame      <= '0;
      r_exec_go    <= 1'b0;
      r_r0_wr_en   <= 1'b0;
      r_r0_wr_data <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_exp_cnt  <= w_cnt_n;
      r_exec_go  <= w_complete;
      r_r0_wr_en <= w_complete && w_r0_sel;
      if (w_complete && w_r0_sel)
        r_r0_wr_data <= Init_R0[CORE_ID*REG_WIDTH +: REG_WIDTH];
      if (w_err)
        r_proto_err <= 1'b1;
      for (int unsigned k = 0; k < INSN_LOAD_TIME; k++) begin
        if (w_store && (Insn_Load_Counter == CNT_W'(k)))
          r_frame[k*INSN_BUS_WIDTH +: INSN_BUS_WIDTH] <= Insn_Data;
      end
    end
  end

  assign Ready      = (r_state != S_EXEC);
  assign frame_data = r_frame;
  assign exec_go    = r_exec_go;
  assign r0_wr_en   = r_r0_wr_en;
  assign r0_wr_data = r_r0_wr_data;
  assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_core_task_receiver.sv
// Directed bench for core_task_receiver: frame assembly, stalls, R0 init, EXEC handshake, protocol errors, reset.
module tb_core_task_receiver;

  localparam int unsigned ID = 2;
  localparam int unsigned NC = 4;
  localparam int unsigned LT = 4;
  localparam int unsigned W  = 64;
  localparam int unsigned RW = 8;

  logic              clk;
  logic              reset;
  logic [NC-1:0]     Start;
  logic [1:0]        cnt;
  logic [W-1:0]      data;
  logic [NC-1:0]     vect;
  logic [NC*RW-1:0]  r0;
  logic              Ready;
  logic [LT*W-1:0]   frame_data;
  logic              exec_go;
  logic              exec_done;
  logic              r0_wr_en;
  logic [RW-1:0]     r0_wr_data;
  logic              proto_err;

  int n_checks;
  int n_pass;

  localparam logic [W-1:0] DA = 64'hAAAA_0000_1111_000A;
  localparam logic [W-1:0] DB = 64'hBBBB_0000_2222_000B;
  localparam logic [W-1:0] DC = 64'hCCCC_0000_3333_000C;
  localparam logic [W-1:0] DD = 64'hDDDD_0000_4444_000D;
  localparam logic [W-1:0] DE = 64'hEEEE_5555_0000_000E;
  localparam logic [W-1:0] DF = 64'hFFFF_6666_0000_000F;
  localparam logic [W-1:0] DG = 64'h1234_7777_0000_0010;
  localparam logic [W-1:0] DH = 64'h5678_8888_0000_0011;

  core_task_receiver #(
    .CORE_ID(ID), .NUM_OF_CORES(NC), .INSN_LOAD_TIME(LT),
    .INSN_BUS_WIDTH(W), .REG_WIDTH(RW)
  ) dut (
    .clk(clk), .reset(reset), .Start(Start), .Insn_Load_Counter(cnt),
    .Insn_Data(data), .Init_R0_Vect(vect), .Init_R0(r0), .Ready(Ready),
    .frame_data(frame_data), .exec_go(exec_go), .exec_done(exec_done),
    .r0_wr_en(r0_wr_en), .r0_wr_data(r0_wr_data), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [W-1:0] d);
    Start     = '0;
    Start[ID] = 1'b1;
    cnt       = c;
    data      = d;
    tick(1);
    Start = '0;
    data  = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
  endtask

  task automatic end_exec(input string name);
    exec_done = 1'b1;
    tick(1);
    exec_done = 1'b0;
    n_checks++;
    if (Ready !== 1'b1) $display("FAIL %s_ready: got %b expected 1", name, Ready); else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(2);
    n_checks++;
    if (Ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", Ready); else n_pass++;
    n_checks++;
    if ({exec_go, r0_wr_en, proto_err} !== 3'b000)
      $display("FAIL rst_pulses: got %b expected 000", {exec_go, r0_wr_en, proto_err}); else n_pass++;
    n_checks++;
    if (frame_data !== '0) $display("FAIL rst_frame: got %h expected 0", frame_data); else n_pass++;
    n_checks++;
    if (r0_wr_data !== 8'h00) $display("FAIL rst_r0data: got %h expected 00", r0_wr_data); else n_pass++;
    reset = 1'b1;
    tick(1);
    n_checks++;
    if (Ready !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", Ready); else n_pass++;
  endtask

  task automatic test_basic_frame;
    send(2'd0, DA);
    n_checks++;
    if ({Ready, exec_go} !== 2'b10) $display("FAIL basic_p0: got %b expected 10", {Ready, exec_go}); else n_pass++;
    send(2'd1, DB);
    send(2'd2, DC);
    n_checks++;
    if (Ready !== 1'b1) $display("FAIL basic_p2_ready: got %b expected 1", Ready); else n_pass++;
    send(2'd3, DD);
    n_checks++;
    if ({Ready, exec_go, r0_wr_en} !== 3'b010)
      $display("FAIL basic_done: got %b expected 010", {Ready, exec_go, r0_wr_en}); else n_pass++;
    n_checks++;
    if (frame_data !== {DD, DC, DB, DA})
      $display("FAIL basic_frame: got %h expected %h", frame_data, {DD, DC, DB, DA}); else n_pass++;
    tick(1);
    n_checks++;
    if ({Ready, exec_go} !== 2'b00) $display("FAIL basic_go_pulse: got %b expected 00", {Ready, exec_go}); else n_pass++;
    end_exec("basic");
  endtask

  task automatic test_stall;
    send(2'd0, DE);
    send(2'd1, DF);
    Start = 4'b1011;
    cnt   = 2'd2;
    data  = DA;
    tick(3);
    Start = '0;
    n_checks++;
    if ({Ready, exec_go, proto_err} !== 3'b100)
      $display("FAIL stall_hold: got %b expected 100", {Ready, exec_go, proto_err}); else n_pass++;
    send(2'd2, DG);
    send(2'd3, DH);
    n_checks++;
    if ({exec_go, proto_err} !== 2'b10) $display("FAIL stall_done: got %b expected 10", {exec_go, proto_err}); else n_pass++;
    n_checks++;
    if (frame_data !== {DH, DG, DF, DE})
      $display("FAIL stall_frame: got %h expected %h", frame_data, {DH, DG, DF, DE}); else n_pass++;
    tick(1);
    end_exec("stall");
  endtask

  task automatic test_r0_init;
    vect     = '0;
    vect[ID] = 1'b1;
    r0       = {8'h11, 8'h5A, 8'h33, 8'h44};
    send(2'd0, DA); send(2'd1, DB); send(2'd2, DC); send(2'd3, DD);
    n_checks++;
    if ({r0_wr_en, r0_wr_data} !== {1'b1, 8'h5A})
      $display("FAIL r0_pulse: got %b/%h expected 1/5a", r0_wr_en, r0_wr_data); else n_pass++;
    tick(1);
    n_checks++;
    if ({r0_wr_en, r0_wr_data} !== {1'b0, 8'h5A})
      $display("FAIL r0_one_cycle: got %b/%h expected 0/5a", r0_wr_en, r0_wr_data); else n_pass++;
    end_exec("r0a");
    vect = 4'b1011;
    r0   = {8'h99, 8'hC3, 8'h77, 8'h66};
    send(2'd0, DA); send(2'd1, DB); send(2'd2, DC); send(2'd3, DD);
    n_checks++;
    if ({exec_go, r0_wr_en, r0_wr_data} !== {1'b1, 1'b0, 8'h5A})
      $display("FAIL r0_nosel: got %b%b/%h expected 10/5a", exec_go, r0_wr_en, r0_wr_data); else n_pass++;
    vect = '0;
    tick(1);
    end_exec("r0b");
  endtask

  task automatic test_exec;
    send(2'd0, DE); send(2'd1, DF); send(2'd2, DG);
    send(2'd3, DH);
    exec_done = 1'b1;
    tick(1);
    exec_done = 1'b0;
    n_checks++;
    if (Ready !== 1'b0) $display("FAIL exec_done_ignored: got %b expected 0", Ready); else n_pass++;
    send(2'd0, DA);
    n_checks++;
    if ({Ready, proto_err} !== 2'b01) $display("FAIL exec_start_err: got %b expected 01", {Ready, proto_err}); else n_pass++;
    n_checks++;
    if (frame_data !== {DH, DG, DF, DE})
      $display("FAIL exec_frame_stable: got %h expected %h", frame_data, {DH, DG, DF, DE}); else n_pass++;
    tick(3);
    n_checks++;
    if (Ready !== 1'b0) $display("FAIL exec_wait: got %b expected 0", Ready); else n_pass++;
    end_exec("exec");
    n_checks++;
    if ({exec_go, proto_err} !== 2'b01) $display("FAIL exec_after: got %b expected 01", {exec_go, proto_err}); else n_pass++;
  endtask

  task automatic test_proto_err;
    do_reset();
    n_checks++;
    if (proto_err !== 1'b0) $display("FAIL err_cleared: got %b expected 0", proto_err); else n_pass++;
    send(2'd2, DA);
    n_checks++;
    if ({Ready, proto_err} !== 2'b11) $display("FAIL err_idle_drop: got %b expected 11", {Ready, proto_err}); else n_pass++;
    n_checks++;
    if (frame_data !== '0) $display("FAIL err_idle_frame: got %h expected 0", frame_data); else n_pass++;
    send(2'd0, DA); send(2'd1, DB); send(2'd3, DD);
    n_checks++;
    if ({Ready, exec_go} !== 2'b10) $display("FAIL err_skip: got %b expected 10", {Ready, exec_go}); else n_pass++;
    send(2'd2, DC); send(2'd3, DD);
    n_checks++;
    if ({Ready, exec_go} !== 2'b10) $display("FAIL err_discarded: got %b expected 10", {Ready, exec_go}); else n_pass++;
    send(2'd0, DE); send(2'd1, DF); send(2'd2, DG); send(2'd3, DH);
    n_checks++;
    if (frame_data !== {DH, DG, DF, DE} || exec_go !== 1'b1)
      $display("FAIL err_recover: got %h/%b expected %h/1", frame_data, exec_go, {DH, DG, DF, DE}); else n_pass++;
    tick(1);
    end_exec("err");
  endtask

  task automatic test_restart;
    do_reset();
    send(2'd0, DA); send(2'd1, DB);
    send(2'd0, DE);
    n_checks++;
    if ({Ready, exec_go, proto_err} !== 3'b101)
      $display("FAIL restart_err: got %b expected 101", {Ready, exec_go, proto_err}); else n_pass++;
    send(2'd1, DF); send(2'd2, DG); send(2'd3, DH);
    n_checks++;
    if (frame_data !== {DH, DG, DF, DE} || exec_go !== 1'b1)
      $display("FAIL restart_frame: got %h/%b expected %h/1", frame_data, exec_go, {DH, DG, DF, DE}); else n_pass++;
    tick(1);
    end_exec("restart");
  endtask

  task automatic test_reset_mid;
    do_reset();
    send(2'd0, DA); send(2'd1, DB);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({Ready, exec_go, proto_err} !== 3'b100)
      $display("FAIL midload_reset: got %b expected 100", {Ready, exec_go, proto_err}); else n_pass++;
    n_checks++;
    if (frame_data !== '0) $display("FAIL midload_frame: got %h expected 0", frame_data); else n_pass++;
    tick(1);
    reset = 1'b1;
    send(2'd2, DC); send(2'd3, DD);
    n_checks++;
    if ({Ready, exec_go} !== 2'b10) $display("FAIL midload_idle: got %b expected 10", {Ready, exec_go}); else n_pass++;
    do_reset();
    send(2'd0, DE); send(2'd1, DF); send(2'd2, DG); send(2'd3, DH);
    n_checks++;
    if (frame_data !== {DH, DG, DF, DE} || {Ready, exec_go} !== 2'b01)
      $display("FAIL fresh_frame: got %h/%b expected %h/01", frame_data, {Ready, exec_go}, {DH, DG, DF, DE}); else n_pass++;
    tick(1);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({Ready, exec_go} !== 2'b10) $display("FAIL midexec_reset: got %b expected 10", {Ready, exec_go}); else n_pass++;
    tick(1);
    reset = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b0;
    Start     = '0;
    cnt       = '0;
    data      = '0;
    vect      = '0;
    r0        = '0;
    exec_done = 1'b0;
    test_reset();
    test_basic_frame();
    test_stall();
    test_r0_init();
    test_exec();
    test_proto_err();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
